// File: rtl/regfile_dbg_pkg.sv
// rtl/regfile_dbg_pkg.sv - shared op encoding, FSM states and sizes for the register file debug port
package regfile_dbg_pkg;

   localparam int NREGS = 32;
   localparam int AW    = 5;
   localparam int DW    = 32;

   typedef enum logic [1:0] {
      OP_READ    = 2'b00,
      OP_WRITE   = 2'b01,
      OP_DUMP    = 2'b10,
      OP_ILLEGAL = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR,
      DUMP_RD,
      RESP,
      DUMP_RESP
   } state_t;

endpackage

// File: rtl/regfile_dbg_if.sv
// rtl/regfile_dbg_if.sv - command/response handshake bundle between a debugger and regfile_dbg
interface regfile_dbg_if;
   import regfile_dbg_pkg::*;

   logic          cmd_val;
   logic          cmd_rdy;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_data;
   logic          resp_val;
   logic          resp_rdy;
   logic [AW-1:0] resp_addr;
   logic [DW-1:0] resp_data;
   logic          resp_last;
   logic          resp_err;

   modport master (
      output cmd_val, cmd_op, cmd_addr, cmd_data, resp_rdy,
      input  cmd_rdy, resp_val, resp_addr, resp_data, resp_last, resp_err
   );

   modport slave (
      input  cmd_val, cmd_op, cmd_addr, cmd_data, resp_rdy,
      output cmd_rdy, resp_val, resp_addr, resp_data, resp_last, resp_err
   );

endinterface

// File: rtl/regfile_dbg.sv
// rtl/regfile_dbg.sv - debug FSM that reads, writes or dumps the core register file while the core stalls
module regfile_dbg
   import regfile_dbg_pkg::*;
#(
   parameter int NREGS = regfile_dbg_pkg::NREGS
) (
   input  logic          clk,
   input  logic          rst,
   regfile_dbg_if.slave  bus,
   output logic          rf_wen,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   output logic [AW-1:0] rf_raddr,
   input  logic [DW-1:0] rf_rdata,
   output logic          dbg_busy
);

   localparam logic [AW-1:0] CNT_LAST = AW'(NREGS - 1);

   state_t        state;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] data_q;
   logic [AW-1:0] cnt;
   logic          resp_val;
   logic [AW-1:0] resp_addr;
   logic [DW-1:0] resp_data;
   logic          resp_last;
   logic          resp_err;

   assign bus.cmd_rdy   = (state == IDLE);
   assign dbg_busy      = (state != IDLE);
   assign bus.resp_val  = resp_val;
   assign bus.resp_addr = resp_addr;
   assign bus.resp_data = resp_data;
   assign bus.resp_last = resp_last;
   assign bus.resp_err  = resp_err;

   assign rf_waddr = addr_q;
   assign rf_wdata = data_q;
   assign rf_raddr = (state == DUMP_RD) ? cnt : addr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         cnt       <= '0;
         resp_val  <= 1'b0;
         resp_addr <= '0;
         resp_data <= '0;
         resp_last <= 1'b0;
         resp_err  <= 1'b0;
         rf_wen    <= 1'b0;
      end else begin
         rf_wen <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cmd_val) begin
                  addr_q <= bus.cmd_addr;
                  data_q <= bus.cmd_data;
                  case (bus.cmd_op)
                     OP_READ:  state <= RD;
                     OP_WRITE: begin
                        state  <= WR;
                        // x0 is hardwired zero, so a write to it never reaches the port
                        rf_wen <= (bus.cmd_addr != '0);
                     end
                     OP_DUMP: begin
                        state <= DUMP_RD;
                        cnt   <= '0;
                     end
                     default: begin
                        state     <= RESP;
                        resp_val  <= 1'b1;
                        resp_addr <= bus.cmd_addr;
                        resp_data <= '0;
                        resp_last <= 1'b1;
                        resp_err  <= 1'b1;
                     end
                  endcase
               end
            end
            RD: begin
               state     <= RESP;
               resp_val  <= 1'b1;
               resp_addr <= addr_q;
               resp_data <= rf_rdata;
               resp_last <= 1'b1;
               resp_err  <= 1'b0;
            end
            WR: begin
               state     <= RESP;
               resp_val  <= 1'b1;
               resp_addr <= addr_q;
               resp_data <= (addr_q == '0) ? '0 : data_q;
               resp_last <= 1'b1;
               resp_err  <= 1'b0;
            end
            DUMP_RD: begin
               state     <= DUMP_RESP;
               resp_val  <= 1'b1;
               resp_addr <= cnt;
               resp_data <= (cnt == '0) ? '0 : rf_rdata;
               resp_last <= (cnt == CNT_LAST);
               resp_err  <= 1'b0;
            end
            RESP: begin
               if (bus.resp_rdy) begin
                  resp_val <= 1'b0;
                  state    <= IDLE;
               end
            end
            DUMP_RESP: begin
               if (bus.resp_rdy) begin
                  resp_val <= 1'b0;
                  if (resp_last) begin
                     state <= IDLE;
                  end else begin
                     cnt   <= cnt + AW'(1);
                     state <= DUMP_RD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/regfile_dbg.md
REGFILE_DBG -- requirements
Module: regfile_dbg

Interface
REQ-001 Parameter: NREGS, default 32, number of architectural registers; addresses 5 bits.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 cmd_val  in  1  command valid.
REQ-005 cmd_rdy  out  1  command ready; a command fires when cmd_val and cmd_rdy are both high.
REQ-006 cmd_op  in  2  00 read, 01 write, 10 dump all, 11 illegal.
REQ-007 cmd_addr  in  5  target register for read or write.
REQ-008 cmd_data  in  32  write data.
REQ-009 resp_val  out  1  response valid.
REQ-010 resp_rdy  in  1  response ready; a response fires when resp_val and resp_rdy are both high.
REQ-011 resp_addr  out  5  register the response refers to.
REQ-012 resp_data  out  32  register value, or written value.
REQ-013 resp_last  out  1  final response of a command.
REQ-014 resp_err  out  1  illegal-op response.
REQ-015 rf_wen  out  1; rf_waddr  out  5; rf_wdata  out  32: register file write port.
REQ-016 rf_raddr  out  5; rf_rdata  in  32: register file read port, combinational read.
REQ-017 dbg_busy  out  1  high when state is not IDLE; the core stalls and yields the regfile ports while it is high.

Function
REQ-018 FSM states: IDLE, RD, WR, DUMP_RD, RESP, DUMP_RESP.
REQ-019 cmd_rdy SHALL be 1 only in IDLE; commands and responses never overlap.
REQ-020 On fire in IDLE, the block latches op, addr and data; next state is RD (op 00), WR (01), DUMP_RD with cnt=0 (10), or RESP with resp_err=1 and resp_data=0 (11).
REQ-021 RD: rf_raddr=addr_q; capture rf_rdata into the response register; go to RESP.
REQ-022 WR: rf_wen=1 for exactly one cycle, rf_waddr=addr_q, rf_wdata=data_q.
REQ-023 WR exception: rf_wen is suppressed when addr_q==0.
REQ-024 WR response data: resp_data=data_q, or 0 when addr_q==0; go to RESP.
REQ-025 Read and write latency: fire at cycle T gives resp_val=1 at T+2; illegal op gives resp_val at T+1.
REQ-026 RESP: resp_last=1; on response fire, return to IDLE; cmd_rdy=1 the following cycle, with no same-cycle bypass.
REQ-027 DUMP_RD: rf_raddr=cnt; capture rf_rdata, with x0 reported as 0; resp_addr=cnt; go to DUMP_RESP.
REQ-028 DUMP_RESP: resp_last=(cnt==NREGS-1).
REQ-029 DUMP_RESP on fire: if last, go to IDLE; else cnt increments and the next state is DUMP_RD.
REQ-030 Dump emits exactly NREGS responses in ascending address order, one every 2 cycles at full rate.
REQ-031 While resp_val=1 and resp_rdy=0, resp_addr, resp_data, resp_last and resp_err SHALL hold stable and the state SHALL not advance.
REQ-032 rf_wen SHALL be 0 in every state except WR.
REQ-033 rf_raddr SHALL be addr_q in states other than DUMP_RD.
REQ-034 The dump counter is 5 bits and never wraps; termination is by the last flag only.

Reset
REQ-035 Asynchronous reset SHALL take effect immediately: state=IDLE, cnt=0, resp_val=0, resp_last=0, resp_err=0, resp_data=0, resp_addr=0, rf_wen=0, dbg_busy=0.
REQ-036 After reset deasserts, cmd_rdy=1 on the first cycle.
REQ-037 Reset mid-write: a WR aborted before its clock edge SHALL not commit (rf_wen drops asynchronously).
REQ-038 Reset mid-dump: the dump is abandoned with no further responses.

Structure
REQ-039 Shared package holds the op encoding (OP_READ, OP_WRITE, OP_DUMP, OP_ILLEGAL), the FSM state enum and NREGS.
REQ-040 No sub-module is required; the FSM, dump counter and response register reside in one module.

Verification
REQ-041 Write op 01, addr 5, data 0xDEADBEEF; then read op 00, addr 5 -> rf_wen pulses once at T+1; read response 0xDEADBEEF, addr 5, last=1 at T+2.
REQ-042 Write addr 0, data 0x12345678 -> rf_wen never asserts; response data 0; subsequent read of addr 0 returns 0.
REQ-043 Preload x1..x31 = 0x100+i, then dump -> 32 responses with addr 0..31, data 0,0x101..0x11F; last=1 only on addr 31; busy high throughout.
REQ-044 Dump with resp_rdy toggling 1,0,0,1 -> data held during stalls, no skipped or duplicated addresses.
REQ-045 Illegal op 11 -> one response at T+1 with err=1, data 0, last=1; no rf_wen.
REQ-046 Assert rst during a dump at addr 10 -> resp_val and busy drop immediately; after release, cmd_rdy=1 and a read of addr 3 works normally.
